// File: rtl/conbus_pkg.sv
// conbus_pkg: shared sizes, FSM encoding and index types for the
// Wishbone slave-side routing stage (conbus_dec).
package conbus_pkg;
    localparam int NMASTER = 7;
    localparam int NSLAVE  = 5;
    localparam int AW      = 32;
    localparam int DW      = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_ERRRESP = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    typedef logic [2:0] sidx_t;
    typedef logic [2:0] midx_t;
endpackage

// File: rtl/conbus_watchdog.sv
// conbus_watchdog: saturating 8-bit cycle counter. Clear has priority over
// enable; o_expire flags that the count has reached TIMEOUT.
module conbus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);
    logic [7:0] r_cnt;

    // Count stalled strobe cycles, holding at 8'hFF instead of wrapping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expire = (r_cnt == 8'(TIMEOUT));
endmodule

// File: rtl/conbus_dec.sv
// conbus_dec: slave-side routing stage downstream of the round-robin arbiter.
// Muxes the granted master onto the shared slave bus, decodes adr[31:29]
// once per bus cycle, and routes ack/err/data back to the owning master.
// Optional watchdog enabled by defining CONBUS_TIMEOUT_EN.
module conbus_dec
    import conbus_pkg::*;
#(
`ifdef CONBUS_TIMEOUT_EN
    parameter int         TIMEOUT = 255,
`endif
    parameter logic [2:0] S0_ADDR = 3'd0,
    parameter logic [2:0] S1_ADDR = 3'd1,
    parameter logic [2:0] S2_ADDR = 3'd2,
    parameter logic [2:0] S3_ADDR = 3'd3,
    parameter logic [2:0] S4_ADDR = 3'd4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [NMASTER-1:0]    gnt,
    input  logic [NMASTER*AW-1:0] m_adr,
    input  logic [NMASTER*DW-1:0] m_dat_w,
    input  logic [NMASTER*4-1:0]  m_sel,
    input  logic [NMASTER-1:0]    m_we,
    input  logic [NMASTER-1:0]    m_cyc,
    input  logic [NMASTER-1:0]    m_stb,
    output logic [DW-1:0]         m_dat_r,
    output logic [NMASTER-1:0]    m_ack,
    output logic [NMASTER-1:0]    m_err,
    output logic [AW-1:0]         s_adr,
    output logic [DW-1:0]         s_dat_w,
    output logic [3:0]            s_sel,
    output logic                  s_we,
    output logic [NSLAVE-1:0]     s_cyc,
    output logic [NSLAVE-1:0]     s_stb,
    input  logic [NSLAVE*DW-1:0]  s_dat_r,
    input  logic [NSLAVE-1:0]     s_ack,
    input  logic [NSLAVE-1:0]     s_err
);
    state_t             r_state;
    sidx_t              r_sel;
    logic               r_hit;
    logic [NMASTER-1:0] r_gnt;

    midx_t              w_gidx;
    logic               w_gvld;
    logic [NMASTER-1:0] w_gone;
    logic               w_cyc;
    logic               w_stb;
    logic [NSLAVE-1:0]  w_match;
    logic               w_multi;
    logic               w_hit;
    sidx_t              w_didx;
    logic               w_gchg;
    logic               w_act;
    logic               w_sack;
    logic               w_serr;
    logic               w_timeout;

    // Lowest set grant bit selects the master; no grant selects nothing
    always_comb begin
        w_gidx = '0;
        w_gvld = 1'b0;
        for (int i = NMASTER - 1; i >= 0; i--) begin
            if (gnt[i]) begin
                w_gidx = midx_t'(i);
                w_gvld = 1'b1;
            end
        end
    end

    assign w_gone = gnt & (~gnt + 7'd1);

    // Master bundle mux onto the shared slave-side signals
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        w_cyc   = 1'b0;
        w_stb   = 1'b0;
        if (w_gvld) begin
            s_adr   = m_adr[AW*int'(w_gidx) +: AW];
            s_dat_w = m_dat_w[DW*int'(w_gidx) +: DW];
            s_sel   = m_sel[4*int'(w_gidx) +: 4];
            s_we    = m_we[w_gidx];
            w_cyc   = m_cyc[w_gidx];
            w_stb   = m_stb[w_gidx];
        end
    end

    // A valid hit needs exactly one matching slave window
    assign w_match = {(s_adr[31:29] == S4_ADDR), (s_adr[31:29] == S3_ADDR),
                      (s_adr[31:29] == S2_ADDR), (s_adr[31:29] == S1_ADDR),
                      (s_adr[31:29] == S0_ADDR)};
    assign w_multi = |(w_match & (w_match - 5'd1));
    assign w_hit   = (|w_match) && !w_multi;

    // Lowest matching slave index
    always_comb begin
        w_didx = '0;
        for (int j = NSLAVE - 1; j >= 0; j--) begin
            if (w_match[j]) begin
                w_didx = sidx_t'(j);
            end
        end
    end

    // Any grant movement away from the captured owner aborts the cycle
    assign w_gchg = (gnt != r_gnt);
    assign w_act  = (r_state == ST_ACTIVE) && !w_gchg;
    assign w_sack = s_ack[r_sel];
    assign w_serr = s_err[r_sel];

`ifdef CONBUS_TIMEOUT_EN
    logic w_wd_en;
    logic w_expire;

    assign w_wd_en = w_act && w_stb && !w_sack && !w_serr;

    conbus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .i_clk    (sys_clk),
        .i_rst_n  (sys_rst_n),
        .i_en     (w_wd_en),
        .i_clr    (!w_wd_en),
        .o_expire (w_expire)
    );

    assign w_timeout = w_wd_en && w_expire;
`else
    assign w_timeout = 1'b0;
`endif

    // Bus-cycle FSM: capture decode once, then hold the select for the cycle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_hit   <= 1'b0;
            r_gnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cyc && w_stb) begin
                        r_sel   <= w_didx;
                        r_hit   <= w_hit;
                        r_gnt   <= gnt;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (w_gchg)     r_state <= ST_IDLE;
                    else if (r_hit) r_state <= ST_ACTIVE;
                    else            r_state <= ST_ERRRESP;
                end
                ST_ACTIVE: begin
                    if (w_gchg || !w_cyc) r_state <= ST_IDLE;
                    else if (w_timeout)   r_state <= ST_ERRRESP;
                end
                ST_ERRRESP: begin
                    if (w_gchg) r_state <= ST_IDLE;
                    else        r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_gchg || !w_cyc) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Combinational forwarding to the selected slave and back to the owner
    always_comb begin
        s_cyc   = '0;
        s_stb   = '0;
        m_ack   = '0;
        m_err   = '0;
        m_dat_r = '0;
        if (w_act) begin
            s_cyc[r_sel] = w_cyc;
            s_stb[r_sel] = w_stb;
            m_dat_r      = s_dat_r[DW*int'(r_sel) +: DW];
            if (w_serr)      m_err = w_gone;
            else if (w_sack) m_ack = w_gone;
        end else if ((r_state == ST_ERRRESP) && !w_gchg) begin
            m_err = w_gone;
        end
    end
endmodule
